// File: rtl/psum_accum_writer.sv
// Receive-side psum accumulator: sums num_pass passes of len_onij vectors into a local
// buffer, then serves registered readout. Optional macro RELU_ON_READ_EN clamps negative readout lanes to 0.
module psum_accum_writer #(
  parameter int unsigned psum_bw  = 16,
  parameter int unsigned col      = 8,
  parameter int unsigned len_onij = 16,
  parameter int unsigned pass_bw  = 4,
  localparam int unsigned ADDR_W  = (len_onij > 1) ? $clog2(len_onij) : 1,
  localparam int unsigned VEC_W   = psum_bw * col
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  input  logic [pass_bw-1:0] num_pass_i,
  input  logic [VEC_W-1:0]  data_i,
  input  logic              valid_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [VEC_W-1:0]  rd_data_o,
  output logic              rd_valid_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              ovf_o,
  output logic              err_o
);

  localparam logic [psum_bw-1:0] SAT_MAX  = {1'b0, {(psum_bw-1){1'b1}}};
  localparam logic [psum_bw-1:0] SAT_MIN  = {1'b1, {(psum_bw-1){1'b0}}};
  localparam logic [ADDR_W-1:0]  LAST_PTR = ADDR_W'(len_onij - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [ADDR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [pass_bw-1:0]   pass_cnt_q, pass_cnt_d;
  logic [pass_bw-1:0]   num_pass_q, num_pass_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 ovf_q, ovf_d;
  logic                 err_q, err_d;
  logic                 rd_valid_q, rd_valid_d;
  logic [VEC_W-1:0]     rd_data_q, rd_data_d;

  logic [VEC_W-1:0]     mem_q [len_onij];
  logic                 mem_we;
  logic [VEC_W-1:0]     mem_wdata;

  logic [VEC_W-1:0]     sat_vec;
  logic                 sat_any;
  logic [VEC_W-1:0]     rd_vec;
  logic                 rd_in_range;
  logic [psum_bw-1:0]   lane_a, lane_b, lane_res;
  logic [psum_bw:0]     lane_sum;

  // Per-lane signed add with one guard bit, clamped on overflow
  always_comb begin
    sat_vec  = '0;
    sat_any  = 1'b0;
    lane_a   = '0;
    lane_b   = '0;
    lane_sum = '0;
    lane_res = '0;
    for (int i = 0; i < int'(col); i++) begin
      lane_a   = mem_q[wr_ptr_q][psum_bw*i +: psum_bw];
      lane_b   = data_i[psum_bw*i +: psum_bw];
      lane_sum = {lane_a[psum_bw-1], lane_a} + {lane_b[psum_bw-1], lane_b};
      if (lane_sum[psum_bw] != lane_sum[psum_bw-1]) begin
        sat_any  = 1'b1;
        lane_res = lane_sum[psum_bw] ? SAT_MIN : SAT_MAX;
      end else begin
        lane_res = lane_sum[psum_bw-1:0];
      end
      sat_vec[psum_bw*i +: psum_bw] = lane_res;
    end
  end

  // Readout lane shaping; out-of-range addresses read as zero
  always_comb begin
    rd_in_range = ({1'b0, rd_addr_i} < (ADDR_W+1)'(len_onij));
    rd_vec      = '0;
    if (rd_in_range) begin
      rd_vec = mem_q[rd_addr_i];
`ifdef RELU_ON_READ_EN
      for (int i = 0; i < int'(col); i++) begin
        if (rd_vec[psum_bw*i + psum_bw - 1]) begin
          rd_vec[psum_bw*i +: psum_bw] = '0;
        end
      end
`endif
    end
  end

  // Next-state, buffer write control and registered output values
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    pass_cnt_d = pass_cnt_q;
    num_pass_d = num_pass_q;
    ovf_d      = ovf_q;
    err_d      = err_q;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    mem_we     = 1'b0;
    mem_wdata  = data_i;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          state_d    = ST_ACCUM;
          wr_ptr_d   = '0;
          pass_cnt_d = '0;
          num_pass_d = (num_pass_i == '0) ? pass_bw'(1) : num_pass_i;
          ovf_d      = 1'b0;
          err_d      = 1'b0;
        end else if (valid_i) begin
          err_d = 1'b1;
        end
      end
      ST_ACCUM: begin
        if (valid_i) begin
          mem_we = 1'b1;
          if (pass_cnt_q != '0) begin
            mem_wdata = sat_vec;
            if (sat_any) begin
              ovf_d = 1'b1;
            end
          end
          if (wr_ptr_q == LAST_PTR) begin
            wr_ptr_d = '0;
            if (pass_cnt_q == num_pass_q - pass_bw'(1)) begin
              state_d = ST_DONE;
            end else begin
              pass_cnt_d = pass_cnt_q + pass_bw'(1);
            end
          end else begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if ((state_q == ST_DONE) && rd_en_i) begin
      rd_valid_d = 1'b1;
      rd_data_d  = rd_vec;
    end

    busy_d = (state_d == ST_ACCUM);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      pass_cnt_q <= '0;
      num_pass_q <= pass_bw'(1);
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      err_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      pass_cnt_q <= pass_cnt_d;
      num_pass_q <= num_pass_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
      err_q      <= err_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // Buffer storage has no reset; contents only matter once written in a tile
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[wr_ptr_q] <= mem_wdata;
    end
  end

  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign ovf_o      = ovf_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_psum_accum_writer.sv
// Randomized bench for psum_accum_writer: a beat-counting reference model checked every
// cycle, plus literal expectations for the directed scenarios.
module tb_psum_accum_writer;

  localparam int LEN = 16;
  localparam int COL = 8;
  localparam int M_IDLE = 0, M_ACCUM = 1, M_DONE = 2;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start_i = 1'b0;
  logic [3:0]   num_pass_i = '0;
  logic [127:0] data_i = '0;
  logic         valid_i = 1'b0;
  logic         rd_en_i = 1'b0;
  logic [3:0]   rd_addr_i = '0;
  logic [127:0] rd_data_o;
  logic         rd_valid_o, busy_o, done_o, ovf_o, err_o;

  psum_accum_writer dut (
    .clk(clk), .reset(reset), .start_i(start_i), .num_pass_i(num_pass_i),
    .data_i(data_i), .valid_i(valid_i), .rd_en_i(rd_en_i), .rd_addr_i(rd_addr_i),
    .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o), .busy_o(busy_o),
    .done_o(done_o), .ovf_o(ovf_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: a tile is "beats received so far"; address and pass follow by division
  int           m_mode = M_IDLE;
  int           m_k = 0;
  int           m_np = 1;
  int           mmem [LEN][COL];
  bit           m_ovf = 1'b0, m_err = 1'b0, m_rdv = 1'b0;
  logic [127:0] m_rdd = '0;

  function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endfunction

  function automatic int lane_of(input logic [127:0] v, input int i);
    logic signed [15:0] t;
    t = v[16*i +: 16];
    return int'(t);
  endfunction

  function automatic logic [127:0] model_read(input int addr);
    logic [127:0] v;
    int x;
    v = '0;
    for (int i = 0; i < COL; i++) begin
      x = mmem[addr][i];
`ifdef RELU_ON_READ_EN
      if (x < 0) x = 0;
`endif
      v[16*i +: 16] = 16'(x);
    end
    return v;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_mode = M_IDLE; m_k = 0; m_ovf = 0; m_err = 0; m_rdv = 0; m_rdd = '0;
    end else begin
      if (m_mode == M_DONE && rd_en_i) begin
        m_rdv = 1'b1;
        m_rdd = model_read(int'(rd_addr_i));
      end else begin
        m_rdv = 1'b0;
      end
      if (m_mode != M_ACCUM) begin
        if (start_i) begin
          m_mode = M_ACCUM; m_k = 0; m_ovf = 0; m_err = 0;
          m_np = (num_pass_i == 0) ? 1 : int'(num_pass_i);
        end else if (valid_i) begin
          m_err = 1'b1;
        end
      end else if (valid_i) begin
        for (int i = 0; i < COL; i++) begin
          int s;
          s = lane_of(data_i, i);
          if (m_k / LEN != 0) s = s + mmem[m_k % LEN][i];
          if (s > 32767) begin s = 32767; m_ovf = 1'b1; end
          else if (s < -32768) begin s = -32768; m_ovf = 1'b1; end
          mmem[m_k % LEN][i] = s;
        end
        m_k++;
        if (m_k == m_np * LEN) m_mode = M_DONE;
      end
    end
    #2;
    chk("busy_o", busy_o, m_mode == M_ACCUM);
    chk("done_o", done_o, m_mode == M_DONE);
    chk("ovf_o", ovf_o, m_ovf);
    chk("err_o", err_o, m_err);
    chk("rd_valid_o", rd_valid_o, m_rdv);
    chk("rd_data_o", rd_data_o, m_rdd);
  end

  task automatic drv(input logic st, input logic [3:0] np, input logic v,
                     input logic [127:0] d, input logic re, input logic [3:0] ra);
    @(negedge clk);
    start_i = st; num_pass_i = np; valid_i = v; data_i = d; rd_en_i = re; rd_addr_i = ra;
  endtask

  // kind: 0 ramp, 1 const 5, 2 random, 3 saturation pattern, 4 sign pattern
  function automatic logic [127:0] gen_vec(input int kind, input int k);
    logic [127:0] v;
    int x;
    v = '0;
    for (int i = 0; i < COL; i++) begin
      case (kind)
        0: x = k * 8 + i;
        1: x = 5;
        2: x = int'($urandom_range(0, 65535));
        3: x = (i != 0) ? 1 : (k % LEN == 0) ? 'h7000 : (k % LEN == 1) ? 'h9000 : 1;
        4: x = (i != 0) ? 0 : (k < LEN) ? 3 : -6;
        default: x = 0;
      endcase
      v[16*i +: 16] = 16'(x);
    end
    return v;
  endfunction

  task automatic run_tile(input int np, input int kind, input int maxgap);
    int n;
    n = (np == 0) ? LEN : np * LEN;
    drv(1'b1, 4'(np), 1'($urandom % 2), gen_vec(2, 0), 1'b0, 4'd0);
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, maxgap))
        drv(($urandom % 8) == 0, 4'($urandom), 1'b0, gen_vec(2, 0), 1'($urandom % 2), 4'($urandom));
      drv(1'b0, 4'd0, 1'b1, gen_vec(kind, k), 1'b0, 4'd0);
    end
    drv(1'b0, 4'd0, 1'b0, '0, 1'b0, 4'd0);
  endtask

  task automatic read_all();
    for (int a = 0; a < LEN; a++) drv(1'b0, 4'd0, 1'b0, '0, 1'b1, 4'(a));
    drv(1'b0, 4'd0, 1'b0, '0, 1'b0, 4'd0);
  endtask

  task automatic pin_read(input string name, input int addr, input int lane, input logic [15:0] exp);
    logic [127:0] got;
    drv(1'b0, 4'd0, 1'b0, '0, 1'b1, 4'(addr));
    drv(1'b0, 4'd0, 1'b0, '0, 1'b0, 4'd0);
    got = rd_data_o;
    chk(name, got[16*lane +: 16], exp);
    chk({name, "_valid"}, rd_valid_o, 1'b1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // Stray beat in IDLE
    drv(1'b0, 4'd0, 1'b1, gen_vec(2, 0), 1'b0, 4'd0);
    drv(1'b0, 4'd0, 1'b0, '0, 1'b0, 4'd0);
    chk("err_in_idle", err_o, 1'b1);

    // Single pass ramp
    run_tile(1, 0, 0);
    chk("t1_done", done_o, 1'b1);
    read_all();
    pin_read("t1_a3_l2", 3, 2, 16'd26);
    pin_read("t1_a15_l7", 15, 7, 16'd127);

    // Stray beat in DONE leaves buffer alone
    drv(1'b0, 4'd0, 1'b1, gen_vec(2, 0), 1'b0, 4'd0);
    drv(1'b0, 4'd0, 1'b0, '0, 1'b0, 4'd0);
    chk("err_in_done", err_o, 1'b1);
    pin_read("t4_a15_l7", 15, 7, 16'd127);

    // Three passes of constant 5 with gaps
    run_tile(3, 1, 3);
    chk("t2_err_cleared", err_o, 1'b0);
    read_all();
    pin_read("t2_a7_l4", 7, 4, 16'd15);

    // Saturation both directions
    run_tile(2, 3, 1);
    chk("t3_ovf", ovf_o, 1'b1);
    pin_read("t3_pos_sat", 0, 0, 16'h7FFF);
    pin_read("t3_neg_sat", 1, 0, 16'h8000);
    pin_read("t3_other_lane", 0, 1, 16'd2);

    // Start with a coincident beat clears sticky flags without setting err
    drv(1'b1, 4'd1, 1'b1, gen_vec(2, 0), 1'b0, 4'd0);
    drv(1'b0, 4'd0, 1'b0, '0, 1'b0, 4'd0);
    chk("t4_err_clr", err_o, 1'b0);
    chk("t4_ovf_clr", ovf_o, 1'b0);
    for (int k = 0; k < LEN; k++) drv(1'b0, 4'd0, 1'b1, gen_vec(2, k), 1'b0, 4'd0);
    drv(1'b0, 4'd0, 1'b0, '0, 1'b0, 4'd0);
    read_all();

    // Reset mid-tile
    drv(1'b1, 4'd1, 1'b0, '0, 1'b0, 4'd0);
    for (int k = 0; k < 7; k++) drv(1'b0, 4'd0, 1'b1, gen_vec(0, k), 1'b0, 4'd0);
    @(negedge clk);
    valid_i = 1'b0;
    reset = 1'b0;
    #1;
    chk("t5_rst_busy", busy_o, 1'b0);
    chk("t5_rst_done", done_o, 1'b0);
    chk("t5_rst_valid", rd_valid_o, 1'b0);
    chk("t5_rst_data", rd_data_o, '0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    run_tile(1, 2, 2);
    read_all();

    // Sign handling on readout
    run_tile(2, 4, 0);
`ifdef RELU_ON_READ_EN
    pin_read("t6_sign", 0, 0, 16'h0000);
`else
    pin_read("t6_sign", 0, 0, 16'hFFFD);
`endif

    // Random tiles with saturating data, gaps, ignored starts/reads and DONE-phase noise
    repeat (8) begin
      run_tile(int'($urandom_range(0, 3)), 2, 2);
      repeat (12)
        drv(1'b0, 4'd0, 1'($urandom % 4 == 0), gen_vec(2, 0), 1'($urandom % 2), 4'($urandom));
    end
    drv(1'b0, 4'd0, 1'b0, '0, 1'b0, 4'd0);
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
